vliw_hazard_ctrl: RTL and testbench

- Parametrised hazard detection and stall sequencer for the VLIW pipeline.
- Sits beside the ID stage.
- Compares source registers of every issue slot in ID against destination registers of all slots in EX (p1) and MEM (p2).
- Computes the required stall depth: 0, 1 or 2 cycles. Drives pc_write, if_id_write and the ID/EX bubble, using an internal counter for multi-cycle stalls.

---
 rtl/vliw_pkg.sv | 20 ++
 rtl/vliw_hazard_ctrl_if.sv | 43 ++++
 rtl/vliw_hazard_ctrl_slot_cmp.sv | 54 +++++
 rtl/vliw_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_vliw_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vliw_pkg.sv
// Shared constants and types for the VLIW hazard controller.
package vliw_pkg;

  localparam int REG_AW_DEF = 3;
  localparam int OP_W_DEF   = 2;
  localparam int FN_W_DEF   = 3;

  localparam logic [OP_W_DEF-1:0] BR_OPCODE_DEF = 2'b01;
  localparam logic [FN_W_DEF-1:0] BR_FUNCT_DEF  = 3'b111;

  // Cause codes are ordered so that a numeric max also applies the
  // tie-break priority branch-load > branch-ALU > load-use.
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_LOAD_USE = 2'b01;
  localparam logic [1:0] CAUSE_BR_ALU   = 2'b10;
  localparam logic [1:0] CAUSE_BR_LOAD  = 2'b11;

  typedef enum logic {ST_IDLE, ST_HOLD} hz_state_e;

endpackage

// File: rtl/vliw_hazard_ctrl_if.sv
// ID-stage hazard inputs and pipeline-control outputs.
interface vliw_hazard_ctrl_if
  import vliw_pkg::*;
#(
  parameter int NUM_SLOTS = 2,
  parameter int NUM_SRC   = 3,
  parameter int REG_AW    = REG_AW_DEF,
  parameter int OP_W      = OP_W_DEF,
  parameter int FN_W      = FN_W_DEF,
  parameter int PERF_W    = 16
);
  logic [NUM_SLOTS-1:0][OP_W-1:0]               id_opcode;
  logic [NUM_SLOTS-1:0][FN_W-1:0]               id_funct;
  logic [NUM_SLOTS-1:0][NUM_SRC-1:0][REG_AW-1:0] id_src;
  logic [NUM_SLOTS-1:0][NUM_SRC-1:0]            id_src_vld;
  logic [NUM_SLOTS-1:0]                         id_valid;
  logic [NUM_SLOTS-1:0]                         p1_memread;
  logic [NUM_SLOTS-1:0]                         p1_regwrite;
  logic [NUM_SLOTS-1:0][REG_AW-1:0]             p1_regdest;
  logic [NUM_SLOTS-1:0]                         p2_memread;
  logic [NUM_SLOTS-1:0]                         p2_regwrite;
  logic [NUM_SLOTS-1:0][REG_AW-1:0]             p2_regdest;
  logic                                         flush;
  logic                                         pc_write;
  logic                                         if_id_write;
  logic                                         id_ex_bubble;
  logic [1:0]                                   stall_cause;
  logic [PERF_W-1:0]                            stall_cnt_perf;

  modport master (
    output id_opcode, id_funct, id_src, id_src_vld, id_valid,
           p1_memread, p1_regwrite, p1_regdest,
           p2_memread, p2_regwrite, p2_regdest, flush,
    input  pc_write, if_id_write, id_ex_bubble, stall_cause, stall_cnt_perf
  );

  modport slave (
    input  id_opcode, id_funct, id_src, id_src_vld, id_valid,
           p1_memread, p1_regwrite, p1_regdest,
           p2_memread, p2_regwrite, p2_regdest, flush,
    output pc_write, if_id_write, id_ex_bubble, stall_cause, stall_cnt_perf
  );
endinterface

// File: rtl/vliw_hazard_ctrl_slot_cmp.sv
// One ID slot against every EX/MEM producer: worst {need, cause} for the slot.
module hazard_slot_cmp
  import vliw_pkg::*;
#(
  parameter int NUM_SLOTS = 2,
  parameter int NUM_SRC   = 3,
  parameter int REG_AW    = REG_AW_DEF,
  parameter int R0_ZERO   = 1
) (
  input  logic [NUM_SRC-1:0][REG_AW-1:0]   src_i,
  input  logic [NUM_SRC-1:0]               src_vld_i,
  input  logic                             valid_i,
  input  logic                             is_br_i,
  input  logic [NUM_SLOTS-1:0]             p1_memread_i,
  input  logic [NUM_SLOTS-1:0]             p1_regwrite_i,
  input  logic [NUM_SLOTS-1:0][REG_AW-1:0] p1_regdest_i,
  input  logic [NUM_SLOTS-1:0]             p2_memread_i,
  input  logic [NUM_SLOTS-1:0]             p2_regwrite_i,
  input  logic [NUM_SLOTS-1:0][REG_AW-1:0] p2_regdest_i,
  output logic [1:0]                       need_o,
  output logic [1:0]                       cause_o
);
  logic [3:0] key, cand;
  logic       live, ex_hit, mem_hit;

  // Scan every source x producer pair; {need,cause} max picks depth then priority.
  always_comb begin
    key     = '0;
    cand    = '0;
    live    = 1'b0;
    ex_hit  = 1'b0;
    mem_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      live = src_vld_i[i] && valid_i && !((R0_ZERO != 0) && (src_i[i] == '0));
      for (int p = 0; p < NUM_SLOTS; p++) begin
        ex_hit  = live && p1_regwrite_i[p] && (p1_regdest_i[p] == src_i[i]);
        mem_hit = live && p2_regwrite_i[p] && (p2_regdest_i[p] == src_i[i]);
        cand    = '0;
        if (is_br_i) begin
          if (ex_hit && p1_memread_i[p])      cand = {2'd2, CAUSE_BR_LOAD};
          else if (ex_hit)                    cand = {2'd1, CAUSE_BR_ALU};
          if (mem_hit && p2_memread_i[p] && (cand < {2'd1, CAUSE_BR_LOAD}))
            cand = {2'd1, CAUSE_BR_LOAD};
        end else if (ex_hit && p1_memread_i[p]) begin
          cand = {2'd1, CAUSE_LOAD_USE};
        end
        if (cand > key) key = cand;
      end
    end
  end

  assign need_o  = key[3:2];
  assign cause_o = key[1:0];
endmodule

// File: rtl/vliw_hazard_ctrl.sv
// Bundle hazard detector and 0/1/2-cycle stall sequencer beside ID.
module vliw_hazard_ctrl
  import vliw_pkg::*;
#(
  parameter int              NUM_SLOTS = 2,
  parameter int              NUM_SRC   = 3,
  parameter int              REG_AW    = REG_AW_DEF,
  parameter int              OP_W      = OP_W_DEF,
  parameter int              FN_W      = FN_W_DEF,
  parameter logic [OP_W-1:0] BR_OPCODE = BR_OPCODE_DEF,
  parameter logic [FN_W-1:0] BR_FUNCT  = BR_FUNCT_DEF,
  parameter int              R0_ZERO   = 1,
  parameter int              PERF_W    = 16
) (
  input logic              clk,
  input logic              rst,
  vliw_hazard_ctrl_if.slave hz
);
  logic [NUM_SLOTS-1:0][1:0] slot_need, slot_cause;
  logic [NUM_SLOTS-1:0]      slot_br;
  logic [3:0]                bkey;
  logic [1:0]                need, cause;

  hz_state_e         state_q, state_d;
  logic              rem_q, rem_d;
  logic [1:0]        cause_q, cause_d;
  logic              stall;
  logic [1:0]        cause_out;
  logic [PERF_W-1:0] perf_q, perf_d;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    assign slot_br[s] = (hz.id_opcode[s] == BR_OPCODE) && (hz.id_funct[s] == BR_FUNCT);

    hazard_slot_cmp #(
      .NUM_SLOTS(NUM_SLOTS), .NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .R0_ZERO(R0_ZERO)
    ) u_cmp (
      .src_i        (hz.id_src[s]),
      .src_vld_i    (hz.id_src_vld[s]),
      .valid_i      (hz.id_valid[s]),
      .is_br_i      (slot_br[s]),
      .p1_memread_i (hz.p1_memread),
      .p1_regwrite_i(hz.p1_regwrite),
      .p1_regdest_i (hz.p1_regdest),
      .p2_memread_i (hz.p2_memread),
      .p2_regwrite_i(hz.p2_regwrite),
      .p2_regdest_i (hz.p2_regdest),
      .need_o       (slot_need[s]),
      .cause_o      (slot_cause[s])
    );
  end

  // Max-reduce {need,cause} across slots.
  always_comb begin
    bkey = '0;
    for (int s = 0; s < NUM_SLOTS; s++)
      if ({slot_need[s], slot_cause[s]} > bkey) bkey = {slot_need[s], slot_cause[s]};
  end

  assign need  = bkey[3:2];
  assign cause = bkey[1:0];

  // Stall sequencer: zero-latency stall in IDLE, one extra held cycle for depth 2.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    cause_d   = cause_q;
    stall     = 1'b0;
    cause_out = CAUSE_NONE;
    if (rst) begin
      state_d = ST_IDLE;
      rem_d   = 1'b0;
      cause_d = CAUSE_NONE;
    end else if (hz.flush) begin
      state_d = ST_IDLE;
      rem_d   = 1'b0;
      cause_d = CAUSE_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (need != 2'd0) begin
            stall     = 1'b1;
            cause_out = cause;
            if (need == 2'd2) begin
              state_d = ST_HOLD;
              rem_d   = 1'b1;
              cause_d = cause;
            end
          end
        end
        ST_HOLD: begin
          // Hazard inputs are ignored here; the latched cause is replayed.
          stall     = 1'b1;
          cause_out = cause_q;
          rem_d     = 1'b0;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign perf_d = (stall && (perf_q != '1)) ? perf_q + PERF_W'(1) : perf_q;

  // State, latched cause and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= 1'b0;
      cause_q <= CAUSE_NONE;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cause_q <= cause_d;
      perf_q  <= perf_d;
    end
  end

  assign hz.pc_write       = ~stall;
  assign hz.if_id_write    = ~stall;
  assign hz.id_ex_bubble   = stall;
  assign hz.stall_cause    = cause_out;
  assign hz.stall_cnt_perf = perf_q;
endmodule

// File: tb/tb_vliw_hazard_ctrl.sv
// Vector table, hand sequences and randomized run against a behavioural model.
module tb_vliw_hazard_ctrl;
  localparam int NS = 2, NSRC = 3, AW = 3;
  localparam logic [1:0] OP_BR = 2'b01, OP_ADD = 2'b00, OP_LW = 2'b10;
  localparam logic [2:0] FN_BR = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vliw_hazard_ctrl_if #(.NUM_SLOTS(NS), .NUM_SRC(NSRC), .REG_AW(AW), .PERF_W(16)) if0 ();
  vliw_hazard_ctrl_if #(.NUM_SLOTS(NS), .NUM_SRC(NSRC), .REG_AW(AW), .PERF_W(4))  if4 ();

  assign if4.id_opcode   = if0.id_opcode;
  assign if4.id_funct    = if0.id_funct;
  assign if4.id_src      = if0.id_src;
  assign if4.id_src_vld  = if0.id_src_vld;
  assign if4.id_valid    = if0.id_valid;
  assign if4.p1_memread  = if0.p1_memread;
  assign if4.p1_regwrite = if0.p1_regwrite;
  assign if4.p1_regdest  = if0.p1_regdest;
  assign if4.p2_memread  = if0.p2_memread;
  assign if4.p2_regwrite = if0.p2_regwrite;
  assign if4.p2_regdest  = if0.p2_regdest;
  assign if4.flush       = if0.flush;

  vliw_hazard_ctrl #(.NUM_SLOTS(NS), .NUM_SRC(NSRC), .REG_AW(AW), .PERF_W(16))
    dut (.clk(clk), .rst(rst), .hz(if0));
  vliw_hazard_ctrl #(.NUM_SLOTS(NS), .NUM_SRC(NSRC), .REG_AW(AW), .PERF_W(4))
    dut4 (.clk(clk), .rst(rst), .hz(if4));

  typedef struct {
    logic [NS-1:0][1:0]          op;
    logic [NS-1:0][2:0]          fn;
    logic [NS-1:0][NSRC-1:0][AW-1:0] src;
    logic [NS-1:0][NSRC-1:0]     sv;
    logic [NS-1:0]               iv;
    logic [NS-1:0]               m1, w1, m2, w2;
    logic [NS-1:0][AW-1:0]       d1, d2;
    logic                        fl;
    logic                        exp_stall;
    logic [1:0]                  exp_cause;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int         m_hold = 0;
  logic [1:0] m_cause = 2'b00;
  int         m_perf0 = 0, m_perf4 = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk();
    vec_t v;
    v.op = '0; v.fn = '0; v.src = '0; v.sv = '1; v.iv = '1;
    v.m1 = '0; v.w1 = '0; v.m2 = '0; v.w2 = '0; v.d1 = '0; v.d2 = '0;
    v.fl = 1'b0; v.exp_stall = 1'b0; v.exp_cause = 2'b00;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    if0.id_opcode = v.op;  if0.id_funct = v.fn;
    if0.id_src = v.src;    if0.id_src_vld = v.sv; if0.id_valid = v.iv;
    if0.p1_memread = v.m1; if0.p1_regwrite = v.w1; if0.p1_regdest = v.d1;
    if0.p2_memread = v.m2; if0.p2_regwrite = v.w2; if0.p2_regdest = v.d2;
    if0.flush = v.fl;
  endtask

  // Worst hazard of the bundle by the textual rules: deeper stall wins,
  // equal depth resolves by cause rank (11 > 10 > 01).
  function automatic void model_need(output int need, output int cause);
    int a;
    bit br;
    need = 0; cause = 0;
    for (int s = 0; s < NS; s++) begin
      br = (if0.id_opcode[s] == OP_BR) && (if0.id_funct[s] == FN_BR);
      for (int i = 0; i < NSRC; i++) begin
        a = int'(if0.id_src[s][i]);
        if (!if0.id_valid[s] || !if0.id_src_vld[s][i] || a == 0) continue;
        for (int p = 0; p < NS; p++) begin
          int n, c;
          n = 0; c = 0;
          if (if0.p1_regwrite[p] && int'(if0.p1_regdest[p]) == a) begin
            if (br) begin n = if0.p1_memread[p] ? 2 : 1; c = if0.p1_memread[p] ? 3 : 2; end
            else if (if0.p1_memread[p]) begin n = 1; c = 1; end
          end
          if (n > need || (n == need && c > cause)) begin need = n; cause = c; end
          if (br && if0.p2_regwrite[p] && if0.p2_memread[p] && int'(if0.p2_regdest[p]) == a) begin
            if (1 > need || (need == 1 && 3 > cause)) begin need = 1; cause = 3; end
          end
        end
      end
    end
  endfunction

  // One clock: check outputs at negedge vs model (and optional fixed
  // expectation), then advance the model and the clock.
  task automatic tick(input bit chk, input bit es, input logic [1:0] ec, input string nm);
    int need, cause;
    bit st;
    logic [1:0] cs;
    @(negedge clk);
    model_need(need, cause);
    if (rst || if0.flush) begin st = 0; cs = 2'b00; end
    else if (m_hold > 0)  begin st = 1; cs = m_cause; end
    else begin st = (need > 0); cs = (need > 0) ? 2'(cause) : 2'b00; end
    cmp({"pc_write ", nm},     32'(if0.pc_write),     32'(!st));
    cmp({"if_id_write ", nm},  32'(if0.if_id_write),  32'(!st));
    cmp({"bubble ", nm},       32'(if0.id_ex_bubble), 32'(st));
    cmp({"cause ", nm},        32'(if0.stall_cause),  32'(cs));
    cmp({"perf16 ", nm},       32'(if0.stall_cnt_perf), 32'(m_perf0));
    cmp({"perf4 ", nm},        32'(if4.stall_cnt_perf), 32'(m_perf4));
    if (chk) begin
      cmp({"vec_stall ", nm}, 32'(if0.id_ex_bubble), 32'(es));
      cmp({"vec_cause ", nm}, 32'(if0.stall_cause),  32'(ec));
    end
    if (rst) begin m_hold = 0; m_perf0 = 0; m_perf4 = 0; end
    else begin
      if (if0.flush) m_hold = 0;
      else if (m_hold > 0) m_hold--;
      else if (need == 2) begin m_hold = 1; m_cause = 2'(cause); end
      if (st) begin
        if (m_perf0 < 65535) m_perf0++;
        if (m_perf4 < 15) m_perf4++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive(mk()); tick(1'b1, 1'b0, 2'b00, "reset");
    rst = 1'b0;
  endtask

  function automatic vec_t br_load();
    vec_t v = mk();
    v.op[0] = OP_BR; v.fn[0] = FN_BR; v.src[0][1] = 3'd5;
    v.m1[1] = 1'b1; v.w1[1] = 1'b1; v.d1[1] = 3'd5;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    // Load-use: slot0 EX lw r3, slot1 add reads r3
    tbl[0] = mk(); tbl[0].op[0] = OP_LW; tbl[0].src[1][0] = 3'd3;
    tbl[0].m1[0] = 1; tbl[0].w1[0] = 1; tbl[0].d1[0] = 3'd3;
    tbl[0].exp_stall = 1; tbl[0].exp_cause = 2'b01;
    // Branch vs EX ALU
    tbl[1] = mk(); tbl[1].op[0] = OP_BR; tbl[1].fn[0] = FN_BR; tbl[1].src[0][0] = 3'd4;
    tbl[1].w1[0] = 1; tbl[1].d1[0] = 3'd4; tbl[1].exp_stall = 1; tbl[1].exp_cause = 2'b10;
    // Branch vs MEM load
    tbl[2] = mk(); tbl[2].op[0] = OP_BR; tbl[2].fn[0] = FN_BR; tbl[2].src[0][2] = 3'd6;
    tbl[2].m2[1] = 1; tbl[2].w2[1] = 1; tbl[2].d2[1] = 3'd6;
    tbl[2].exp_stall = 1; tbl[2].exp_cause = 2'b11;
    // r0 never hazards
    tbl[3] = mk(); tbl[3].op[0] = OP_BR; tbl[3].fn[0] = FN_BR;
    tbl[3].m1[0] = 1; tbl[3].w1[0] = 1; tbl[3].d1[0] = 3'd0;
    // consumer slot not valid
    tbl[4] = tbl[0]; tbl[4].iv[1] = 0; tbl[4].exp_stall = 0; tbl[4].exp_cause = 2'b00;
    // source not read
    tbl[5] = tbl[0]; tbl[5].sv[1][0] = 0; tbl[5].exp_stall = 0; tbl[5].exp_cause = 2'b00;
    // producer not writing
    tbl[6] = tbl[0]; tbl[6].w1[0] = 0; tbl[6].exp_stall = 0; tbl[6].exp_cause = 2'b00;
    // non-branch vs EX ALU: forwarding covers it
    tbl[7] = tbl[0]; tbl[7].m1[0] = 0; tbl[7].exp_stall = 0; tbl[7].exp_cause = 2'b00;
    // non-branch vs MEM load
    tbl[8] = mk(); tbl[8].src[1][0] = 3'd3; tbl[8].m2[0] = 1; tbl[8].w2[0] = 1; tbl[8].d2[0] = 3'd3;
    // flush beats branch-load
    tbl[9] = br_load(); tbl[9].fl = 1;
    // tie at depth 1: load-use vs branch-ALU -> branch-ALU
    tbl[10] = mk(); tbl[10].src[0][0] = 3'd2; tbl[10].m1[0] = 1; tbl[10].w1[0] = 1; tbl[10].d1[0] = 3'd2;
    tbl[10].op[1] = OP_BR; tbl[10].fn[1] = FN_BR; tbl[10].src[1][0] = 3'd5;
    tbl[10].w1[1] = 1; tbl[10].d1[1] = 3'd5; tbl[10].exp_stall = 1; tbl[10].exp_cause = 2'b10;
    // tie at depth 1: branch-ALU vs branch MEM load -> branch-load
    tbl[11] = mk(); tbl[11].op[0] = OP_BR; tbl[11].fn[0] = FN_BR;
    tbl[11].src[0][0] = 3'd4; tbl[11].w1[0] = 1; tbl[11].d1[0] = 3'd4;
    tbl[11].src[0][1] = 3'd6; tbl[11].m2[0] = 1; tbl[11].w2[0] = 1; tbl[11].d2[0] = 3'd6;
    tbl[11].exp_stall = 1; tbl[11].exp_cause = 2'b11;

    drive(mk());
    @(posedge clk); #1;
    do_reset();

    for (int k = 0; k < 12; k++) begin
      drive(tbl[k]);
      tick(1'b1, tbl[k].exp_stall, tbl[k].exp_cause, $sformatf("vec%0d", k));
      drive(mk());
      tick(1'b0, 1'b0, 2'b00, $sformatf("vec%0d_idle", k));
    end

    // Load-use then release; one stalled cycle counted
    do_reset();
    drive(tbl[0]); tick(1'b1, 1'b1, 2'b01, "lu_c1");
    drive(mk());   tick(1'b1, 1'b0, 2'b00, "lu_c2");
    cmp("lu_perf", 32'(if0.stall_cnt_perf), 32'd1);

    // Branch-load: two stalls, second ignores cleared inputs
    do_reset();
    drive(br_load()); tick(1'b1, 1'b1, 2'b11, "bl_c1");
    drive(mk());      tick(1'b1, 1'b1, 2'b11, "bl_c2");
    tick(1'b1, 1'b0, 2'b00, "bl_c3");
    cmp("bl_perf", 32'(if0.stall_cnt_perf), 32'd2);

    // Flush during the held cycle
    drive(br_load()); tick(1'b1, 1'b1, 2'b11, "fh_c1");
    drive(mk()); if0.flush = 1'b1; tick(1'b1, 1'b0, 2'b00, "fh_c2");
    if0.flush = 1'b0; tick(1'b1, 1'b0, 2'b00, "fh_c3");

    // Reset during the held cycle
    drive(br_load()); tick(1'b1, 1'b1, 2'b11, "rh_c1");
    rst = 1'b1; tick(1'b1, 1'b0, 2'b00, "rh_c2");
    rst = 1'b0; drive(mk()); tick(1'b1, 1'b0, 2'b00, "rh_c3");
    cmp("rh_perf", 32'(if0.stall_cnt_perf), 32'd0);

    // Saturation of the 4-bit counter
    do_reset();
    drive(tbl[0]);
    for (int k = 0; k < 20; k++) tick(1'b1, 1'b1, 2'b01, "sat");
    drive(mk()); tick(1'b0, 1'b0, 2'b00, "sat_end");
    cmp("sat_perf4", 32'(if4.stall_cnt_perf), 32'd15);
    cmp("sat_perf16", 32'(if0.stall_cnt_perf), 32'd20);

    // Randomized run, small register space for frequent hits
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int s = 0; s < NS; s++) begin
        if ($urandom_range(0, 2) == 0) begin if0.id_opcode[s] = OP_BR; if0.id_funct[s] = FN_BR; end
        else begin if0.id_opcode[s] = 2'($urandom_range(0, 3)); if0.id_funct[s] = 3'($urandom_range(0, 7)); end
        for (int i = 0; i < NSRC; i++) begin
          if0.id_src[s][i]     = 3'($urandom_range(0, 3));
          if0.id_src_vld[s][i] = ($urandom_range(0, 3) != 0);
        end
        if0.id_valid[s]    = ($urandom_range(0, 7) != 0);
        if0.p1_memread[s]  = 1'($urandom_range(0, 1));
        if0.p1_regwrite[s] = 1'($urandom_range(0, 1));
        if0.p1_regdest[s]  = 3'($urandom_range(0, 3));
        if0.p2_memread[s]  = 1'($urandom_range(0, 1));
        if0.p2_regwrite[s] = 1'($urandom_range(0, 1));
        if0.p2_regdest[s]  = 3'($urandom_range(0, 3));
      end
      if0.flush = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 63) == 0);
      tick(1'b0, 1'b0, 2'b00, "rand");
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
